// File: rtl/hamming_gen.sv
// hamming_gen: 24-bit line/column parity ECC over a 512-byte sector, compared
// against the stored spare-area ECC to produce a syndrome for the decoder.
module hamming_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        data_valid,
    input  logic [7:0]  data_in,
    input  logic        ecc_valid,
    input  logic [7:0]  ecc_in,
    output logic [23:0] ecc_out,
    output logic [23:0] hamming_result,
    output logic        hamming_en,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, DATA, ECC, CMP} state_t;
    state_t      r_state;
    logic [8:0]  r_byte_cnt;
    logic [1:0]  r_ecc_cnt;
    logic [23:0] r_acc, r_stored, r_ecc_out, r_result;
    logic        r_en;
    logic        w_p;
    logic [23:0] w_acc_next;
    // Low six bits split on bit_index; the rest on byte_index using the byte parity.
    always_comb begin
        w_p = ^data_in;
        w_acc_next = r_acc;
        w_acc_next[0] = r_acc[0] ^ (^(data_in & 8'h55));
        w_acc_next[1] = r_acc[1] ^ (^(data_in & 8'hAA));
        w_acc_next[2] = r_acc[2] ^ (^(data_in & 8'h33));
        w_acc_next[3] = r_acc[3] ^ (^(data_in & 8'hCC));
        w_acc_next[4] = r_acc[4] ^ (^(data_in & 8'h0F));
        w_acc_next[5] = r_acc[5] ^ (^(data_in & 8'hF0));
        for (int k = 0; k < 9; k++) begin
            w_acc_next[2*k+6] = r_acc[2*k+6] ^ (w_p & ~r_byte_cnt[k]);
            w_acc_next[2*k+7] = r_acc[2*k+7] ^ (w_p & r_byte_cnt[k]);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_byte_cnt <= '0;
            r_ecc_cnt  <= '0;
            r_acc      <= '0;
            r_stored   <= '0;
            r_ecc_out  <= '0;
            r_result   <= '0;
            r_en       <= 1'b0;
        end else if (start) begin
            r_state    <= DATA;
            r_byte_cnt <= '0;
            r_ecc_cnt  <= '0;
            r_acc      <= '0;
            r_stored   <= '0;
            r_ecc_out  <= '0;
            r_result   <= '0;
            r_en       <= 1'b0;
        end else begin
            r_en <= 1'b0;
            case (r_state)
                DATA: if (data_valid) begin
                    r_acc      <= w_acc_next;
                    r_byte_cnt <= r_byte_cnt + 9'd1;
                    if (r_byte_cnt == 9'd511) begin
                        r_ecc_out <= w_acc_next;
                        r_state   <= ECC;
                    end
                end
                ECC: if (ecc_valid) begin
                    r_stored[{r_ecc_cnt, 3'b000} +: 8] <= ecc_in;
                    r_ecc_cnt <= (r_ecc_cnt == 2'd2) ? 2'd0 : r_ecc_cnt + 2'd1;
                    if (r_ecc_cnt == 2'd2) r_state <= CMP;
                end
                CMP: begin
                    r_result <= r_ecc_out ^ r_stored;
                    r_en     <= 1'b1;
                    r_state  <= IDLE;
                end
                default: ;
            endcase
        end
    end
    assign ecc_out        = r_ecc_out;
    assign hamming_result = r_result;
    assign hamming_en     = r_en;
    assign busy           = (r_state != IDLE);
endmodule

// File: tb/tb_hamming_gen.sv
// tb_hamming_gen: randomized sectors checked against a bit-address parity model.
module tb_hamming_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        data_valid = 1'b0;
    logic [7:0]  data_in = '0;
    logic        ecc_valid = 1'b0;
    logic [7:0]  ecc_in = '0;
    logic [23:0] ecc_out, hamming_result;
    logic        hamming_en, busy;
    int total = 0;
    int bad = 0;
    int en_cnt = 0;
    logic [7:0] sec [512];

    hamming_gen dut (
        .clk(clk), .rst(rst), .start(start),
        .data_valid(data_valid), .data_in(data_in),
        .ecc_valid(ecc_valid), .ecc_in(ecc_in),
        .ecc_out(ecc_out), .hamming_result(hamming_result),
        .hamming_en(hamming_en), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (hamming_en) en_cnt <= en_cnt + 1;

    function automatic logic [23:0] golden();
        logic [23:0] e = '0;
        for (int a = 0; a < 4096; a++)
            if (sec[a / 8][a % 8])
                for (int k = 0; k < 12; k++) e[2*k + ((a >> k) & 1)] ^= 1'b1;
        return e;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // Gap cycles carry noise on the input that the current phase must ignore.
    task automatic send_sector(input int gap_max);
        for (int i = 0; i < 512; i++) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin
                ecc_valid = 1'b1;
                ecc_in = 8'($urandom);
                cyc();
                ecc_valid = 1'b0;
            end
            data_valid = 1'b1;
            data_in = sec[i];
            cyc();
            data_valid = 1'b0;
        end
    endtask

    task automatic send_ecc(input logic [23:0] e, input int n, input int gap_max);
        for (int j = 0; j < n; j++) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin
                data_valid = 1'b1;
                data_in = 8'($urandom);
                cyc();
                data_valid = 1'b0;
            end
            ecc_valid = 1'b1;
            ecc_in = e[8*j +: 8];
            cyc();
            ecc_valid = 1'b0;
        end
    endtask

    task automatic run_full(input string name, input logic [23:0] st, input int gap_max);
        logic [23:0] g = golden();
        int e0;
        pulse_start();
        send_sector(gap_max);
        total++;
        if (ecc_out !== g) begin
            bad++;
            $display("FAIL %s ecc_out got %h exp %h", name, ecc_out, g);
        end
        e0 = en_cnt;
        send_ecc(st, 3, gap_max);
        total++;
        if (hamming_en !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s cmp_cycle en=%b busy=%b exp en=0 busy=1", name, hamming_en, busy);
        end
        cyc();
        total++;
        if (hamming_en !== 1'b1 || hamming_result !== (g ^ st) || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s result en=%b res=%h busy=%b exp en=1 res=%h busy=0",
                     name, hamming_en, hamming_result, busy, g ^ st);
        end
        repeat (3) cyc();
        total++;
        if (en_cnt - e0 !== 1 || hamming_result !== (g ^ st) || ecc_out !== g) begin
            bad++;
            $display("FAIL %s hold pulses=%0d res=%h ecc=%h exp 1 %h %h",
                     name, en_cnt - e0, hamming_result, ecc_out, g ^ st, g);
        end
    endtask

    task automatic test_reset();
        repeat (3) cyc();
        total++;
        if (ecc_out !== 24'h0 || hamming_result !== 24'h0 || hamming_en !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset ecc=%h res=%h en=%b busy=%b exp all 0", ecc_out, hamming_result, hamming_en, busy);
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_fixed();
        logic [23:0] g;
        foreach (sec[i]) sec[i] = 8'h00;
        run_full("zero", 24'h0, 0);
        foreach (sec[i]) sec[i] = 8'hFF;
        run_full("ones", 24'h0, 0);
        foreach (sec[i]) sec[i] = 8'h00;
        sec[5] = 8'h08;
        g = golden();
        total++;
        if (g !== 24'h55599A) begin
            bad++;
            $display("FAIL model_single_bit got %h exp 55599a", g);
        end
        run_full("single_bit", 24'h0, 0);
        total++;
        if (hamming_result !== 24'h55599A) begin
            bad++;
            $display("FAIL single_bit_const got %h exp 55599a", hamming_result);
        end
        run_full("match", 24'h55599A, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 3; n++) begin
            foreach (sec[i]) sec[i] = 8'($urandom);
            run_full("random", 24'($urandom), 2);
        end
    endtask

    task automatic test_start_with_data();
        foreach (sec[i]) sec[i] = 8'h00;
        start = 1'b1;
        data_valid = 1'b1;
        data_in = 8'hFF;
        cyc();
        start = 1'b0;
        data_valid = 1'b0;
        send_sector(0);
        total++;
        if (ecc_out !== 24'h0) begin
            bad++;
            $display("FAIL start_with_data ecc_out got %h exp 000000", ecc_out);
        end
        send_ecc(24'h0, 3, 0);
        repeat (3) cyc();
    endtask

    task automatic test_abort_stall();
        int e0 = en_cnt;
        logic [23:0] st = 24'($urandom);
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            data_valid = 1'b1;
            data_in = 8'($urandom);
            cyc();
        end
        data_valid = 1'b0;
        foreach (sec[i]) sec[i] = 8'($urandom);
        pulse_start();
        send_sector(3);
        send_ecc(st, 3, 3);
        repeat (4) cyc();
        total++;
        if (en_cnt - e0 !== 1 || hamming_result !== (golden() ^ st)) begin
            bad++;
            $display("FAIL abort_stall pulses=%0d res=%h exp 1 %h", en_cnt - e0, hamming_result, golden() ^ st);
        end
    endtask

    task automatic test_reset_mid_ecc();
        int e0;
        foreach (sec[i]) sec[i] = 8'h00;
        sec[5] = 8'h08;
        pulse_start();
        send_sector(0);
        send_ecc(24'h123456, 2, 0);
        e0 = en_cnt;
        rst = 1'b1;
        start = 1'b1;
        cyc();
        rst = 1'b0;
        start = 1'b0;
        total++;
        if (ecc_out !== 24'h0 || hamming_result !== 24'h0 || hamming_en !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_ecc ecc=%h res=%h en=%b busy=%b exp all 0", ecc_out, hamming_result, hamming_en, busy);
        end
        send_ecc(24'h0000AB, 1, 0);
        repeat (4) cyc();
        total++;
        if (en_cnt !== e0 || busy !== 1'b0 || hamming_result !== 24'h0) begin
            bad++;
            $display("FAIL reset_ecc_ignored pulses=%0d busy=%b res=%h exp 0 0 0", en_cnt - e0, busy, hamming_result);
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_random();
        test_start_with_data();
        test_abort_stall();
        test_reset_mid_ecc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hamming_gen.md
HAMMING_GEN -- requirements
Module: hamming_gen

Interface
REQ-001 clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 start  input  1  one-cycle pulse; clears the accumulator and begins a new 512-byte sector.
REQ-004 data_valid  input  1  data_in carries a sector byte this cycle.
REQ-005 data_in  input  8  sector byte, in ascending byte address order.
REQ-006 ecc_valid  input  1  ecc_in carries a stored spare-area ECC byte this cycle.
REQ-007 ecc_in  input  8  stored ECC byte, low byte first (bits 7:0, then 15:8, then 23:16).
REQ-008 ecc_out  output  24  computed ECC of the sector, held until the next start.
REQ-009 hamming_result  output  24  ecc_out XOR stored ECC, held until the next start; feeds the downstream syndrome decoder.
REQ-010 hamming_en  output  1  one-cycle pulse; hamming_result is valid from this cycle on.
REQ-011 busy  output  1  high in the DATA, ECC and CMP states.

Function
REQ-012 Bit address A[11:0] SHALL be {byte_index[8:0], bit_index[2:0]}, where byte_index counts 0..511 and bit_index selects the bit within data_in.
REQ-013 For each pair k = 0..11, ECC bit 2k+1 SHALL be the XOR of all sector bits whose A[k] = 1, and ECC bit 2k SHALL be the XOR of all sector bits whose A[k] = 0.
REQ-014 The accumulator SHALL absorb one byte per cycle with no stall, so a sector takes 512 accepted bytes.
REQ-015 The FSM SHALL have four states: IDLE, DATA, ECC, CMP.
- IDLE: start -> DATA.
- DATA: advances after the 512th accepted byte (byte counter wraps 511 -> 0) -> ECC.
- ECC: advances after the 3rd accepted ecc byte -> CMP.
- CMP: one cycle, then -> IDLE.
REQ-016 start SHALL clear the accumulator, the byte counter, the ecc byte counter and the stored-ECC register, and enter DATA.
REQ-017 start SHALL act this way in any state, including mid-sector, where it aborts the current sector without raising hamming_en.
REQ-018 In DATA, ecc_valid SHALL be ignored; in ECC, data_valid SHALL be ignored; in IDLE and CMP, both SHALL be ignored.
REQ-019 If start and data_valid are high in the same cycle, the byte SHALL be ignored; the first sector byte is taken no earlier than the cycle after start.
REQ-020 ecc_out SHALL update in the cycle the 512th byte is accepted and SHALL remain stable until the next start or rst.
REQ-021 In CMP, hamming_result SHALL be registered as ecc_out XOR stored ECC, and hamming_en SHALL be high for exactly that one cycle.
REQ-022 Latency: hamming_en SHALL rise on the clock edge after the edge that accepts the 3rd ecc byte.
REQ-023 hamming_result SHALL change only in CMP, on start (cleared to 0) and on rst.
REQ-024 Gaps in data_valid or ecc_valid (idle cycles) SHALL be tolerated with no limit on their length.

Reset
REQ-025 On rst: state IDLE; ecc_out = 0; hamming_result = 0; hamming_en = 0; busy = 0; all counters and the stored-ECC register = 0.
REQ-026 rst SHALL take priority over start and over every valid input in the same cycle.
REQ-027 rst asserted mid-sector SHALL discard the partial sector, and no hamming_en SHALL follow.

Verification
REQ-028 Zero sector: start, 512 x 0x00, then ecc bytes 00,00,00 -> ecc_out = 0x000000, hamming_result = 0x000000, one hamming_en pulse.
REQ-029 Ones sector: 512 x 0xFF, then ecc bytes 00,00,00 -> ecc_out = 0x000000, hamming_result = 0x000000.
REQ-030 Single bit: all bytes 0x00 except byte 5 = 0x08 (A = 43), then ecc bytes 00,00,00 -> ecc_out = 0x55599A, hamming_result = 0x55599A (popcount 12).
REQ-031 Matching stored ECC: the REQ-030 sector with ecc bytes 9A,59,55 -> hamming_result = 0x000000.
REQ-032 Abort and stall: start, 100 bytes, start again, a full sector with random data_valid gaps, ecc bytes -> exactly one hamming_en pulse, with a result equal to a golden model of the second sector only.
REQ-033 Reset mid-ECC: rst after 2 ecc bytes -> all outputs 0, state IDLE, no hamming_en; a following ecc_valid is ignored.
